// File: rtl/gate_bist_if.sv
// Stimulus/response bus between the gate BIST engine and the INV/NAND2 gate DUTs.
interface gate_bist_if #(
  parameter int unsigned WIDTH = 64
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out_inv;
  logic [WIDTH-1:0] out_nand2;

  modport master (output in1, output in2, input out_inv, input out_nand2);
  modport slave  (input in1, input in2, output out_inv, output out_nand2);
endinterface

// File: rtl/gate_bist.sv
// On-chip LFSR stimulus generator and INV/NAND2 response checker with
// latency-matched compare, saturating error count and first-fail capture.
module gate_bist #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned NUM_VECTORS = 1024,
  parameter int unsigned LATENCY     = 0,
  parameter logic [63:0] SEED        = 64'hACE1_0000_0000_0001,
  parameter int unsigned ERR_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  gate_bist_if.master        bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [31:0]        first_fail_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0] NV_LAST  = 32'(NUM_VECTORS - 1);
  localparam logic [2:0]  DLAST    = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);
  localparam logic [63:0] SEED_ROT = {SEED[31:0], SEED[63:32]};

  state_t           state;
  logic [63:0]      lfsr;
  logic [63:0]      lfsr_rot;
  logic [31:0]      vidx;
  logic [2:0]       dcnt;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic             run_valid;

  logic [WIDTH-1:0] c_in1;
  logic [WIDTH-1:0] c_in2;
  logic             c_valid;
  logic [31:0]      c_idx;
  logic             fail;

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  assign lfsr_rot  = {lfsr[31:0], lfsr[63:32]};
  assign run_valid = (state == S_RUN);
  assign bus.in1   = in1_q;
  assign bus.in2   = in2_q;
  assign pass      = done && (err_count == '0);

  // Expected values are recomputed from the delayed stimulus, so the pipeline
  // carries the operands themselves rather than precomputed expectations.
  generate
    if (LATENCY == 0) begin : g_nopipe
      assign c_in1   = in1_q;
      assign c_in2   = in2_q;
      assign c_valid = run_valid;
      assign c_idx   = vidx;
    end else begin : g_pipe
      logic [WIDTH-1:0] p_in1 [LATENCY];
      logic [WIDTH-1:0] p_in2 [LATENCY];
      logic             p_v   [LATENCY];
      logic [31:0]      p_idx [LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < LATENCY; i++) begin
            p_in1[i] <= '0;
            p_in2[i] <= '0;
            p_v[i]   <= 1'b0;
            p_idx[i] <= '0;
          end
        end else begin
          p_in1[0] <= in1_q;
          p_in2[0] <= in2_q;
          p_v[0]   <= run_valid;
          p_idx[0] <= vidx;
          for (int unsigned i = 1; i < LATENCY; i++) begin
            p_in1[i] <= p_in1[i-1];
            p_in2[i] <= p_in2[i-1];
            p_v[i]   <= p_v[i-1];
            p_idx[i] <= p_idx[i-1];
          end
        end
      end

      assign c_in1   = p_in1[LATENCY-1];
      assign c_in2   = p_in2[LATENCY-1];
      assign c_valid = p_v[LATENCY-1];
      assign c_idx   = p_idx[LATENCY-1];
    end
  endgenerate

  assign fail = c_valid &&
                ((bus.out_inv != ~c_in1) || (bus.out_nand2 != ~(c_in1 & c_in2)));

  // lfsr holds the value for the next vector; in1_q/in2_q hold the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      lfsr           <= SEED;
      vidx           <= '0;
      dcnt           <= '0;
      in1_q          <= '0;
      in2_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '1;
    end else begin
      if (fail) begin
        if (err_count != '1)
          err_count <= err_count + ERR_W'(1);
        if (first_fail_idx == '1)
          first_fail_idx <= c_idx;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            lfsr           <= lfsr_step(SEED);
            vidx           <= '0;
            in1_q          <= SEED[WIDTH-1:0];
            in2_q          <= SEED_ROT[WIDTH-1:0];
            err_count      <= '0;
            first_fail_idx <= '1;
          end
        end
        S_RUN: begin
          if (vidx == NV_LAST) begin
            in1_q <= '0;
            in2_q <= '0;
            if (LATENCY == 0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
              dcnt  <= '0;
            end
          end else begin
            vidx  <= vidx + 32'd1;
            lfsr  <= lfsr_step(lfsr);
            in1_q <= lfsr[WIDTH-1:0];
            in2_q <= lfsr_rot[WIDTH-1:0];
          end
        end
        S_DRAIN: begin
          if (dcnt == DLAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: six instances cover clean, stimulus, fault,
// saturation, latency and reset/restart scenarios.
module tb_gate_bist;

  localparam logic [63:0] SEED = 64'hACE1_0000_0000_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] st = '0;
  logic a_fault = 1'b0;
  logic [63:0] v7;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  gate_bist_if #(.WIDTH(64)) bus_a ();
  gate_bist_if #(.WIDTH(64)) bus_b ();
  gate_bist_if #(.WIDTH(64)) bus_c ();
  gate_bist_if #(.WIDTH(64)) bus_d ();
  gate_bist_if #(.WIDTH(64)) bus_e ();
  gate_bist_if #(.WIDTH(64)) bus_f ();

  logic busy_a, done_a, pass_a; logic [15:0] err_a; logic [31:0] ffi_a;
  logic busy_b, done_b, pass_b; logic [15:0] err_b; logic [31:0] ffi_b;
  logic busy_c, done_c, pass_c; logic [15:0] err_c; logic [31:0] ffi_c;
  logic busy_d, done_d, pass_d; logic [3:0]  err_d; logic [31:0] ffi_d;
  logic busy_e, done_e, pass_e; logic [15:0] err_e; logic [31:0] ffi_e;
  logic busy_f, done_f, pass_f; logic [15:0] err_f; logic [31:0] ffi_f;
  logic [5:0] done_v;
  assign done_v = {done_f, done_e, done_d, done_c, done_b, done_a};

  // gate models
  assign bus_a.out_inv   = (a_fault && bus_a.in1 == v7) ? bus_a.in1 : ~bus_a.in1;
  assign bus_a.out_nand2 = ~(bus_a.in1 & bus_a.in2);
  assign bus_b.out_inv   = ~bus_b.in1;
  assign bus_b.out_nand2 = ~(bus_b.in1 & bus_b.in2);
  assign bus_c.out_inv   = ~bus_c.in1;
  assign bus_c.out_nand2 = bus_c.in1 & bus_c.in2;
  assign bus_d.out_inv   = bus_d.in1;
  assign bus_d.out_nand2 = ~(bus_d.in1 & bus_d.in2);
  always @(posedge clk) begin
    bus_e.out_inv   <= ~bus_e.in1;
    bus_e.out_nand2 <= ~(bus_e.in1 & bus_e.in2);
    bus_f.out_inv   <= ~bus_f.in1;
    bus_f.out_nand2 <= ~(bus_f.in1 & bus_f.in2);
  end

  gate_bist #(.WIDTH(64), .NUM_VECTORS(1024), .LATENCY(0), .ERR_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .bus(bus_a.master), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail_idx(ffi_a));
  gate_bist #(.WIDTH(64), .NUM_VECTORS(4), .LATENCY(0), .ERR_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .bus(bus_b.master), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail_idx(ffi_b));
  gate_bist #(.WIDTH(64), .NUM_VECTORS(16), .LATENCY(0), .ERR_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .bus(bus_c.master), .busy(busy_c),
    .done(done_c), .pass(pass_c), .err_count(err_c), .first_fail_idx(ffi_c));
  gate_bist #(.WIDTH(64), .NUM_VECTORS(20), .LATENCY(0), .ERR_W(4)) u_d (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .bus(bus_d.master), .busy(busy_d),
    .done(done_d), .pass(pass_d), .err_count(err_d), .first_fail_idx(ffi_d));
  gate_bist #(.WIDTH(64), .NUM_VECTORS(16), .LATENCY(1), .ERR_W(16)) u_e (
    .clk(clk), .rst_n(rst_n), .start(st[4]), .bus(bus_e.master), .busy(busy_e),
    .done(done_e), .pass(pass_e), .err_count(err_e), .first_fail_idx(ffi_e));
  gate_bist #(.WIDTH(64), .NUM_VECTORS(16), .LATENCY(0), .ERR_W(16)) u_f (
    .clk(clk), .rst_n(rst_n), .start(st[5]), .bus(bus_f.master), .busy(busy_f),
    .done(done_f), .pass(pass_f), .err_count(err_f), .first_fail_idx(ffi_f));

  function automatic logic [63:0] m_step(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  function automatic logic [63:0] m_rot(input logic [63:0] l);
    return {l[31:0], l[63:32]};
  endfunction

  // Pulse start on one instance; cycles counts edges from the start edge inclusive.
  task automatic pulse_and_wait(input int unsigned id, input int unsigned limit,
                                output int unsigned cycles);
    @(negedge clk); st[id] = 1'b1;
    @(posedge clk); cycles = 1; #1 st[id] = 1'b0;
    while (!done_v[id] && cycles < limit) begin
      @(posedge clk); cycles++; #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done_a); end
    n_cmp++; if (pass_a !== 1'b0) begin n_bad++; $display("FAIL reset_pass got %b exp 0", pass_a); end
    n_cmp++; if (err_a !== 16'd0) begin n_bad++; $display("FAIL reset_err got %h exp 0", err_a); end
    n_cmp++; if (ffi_a !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_ffi got %h exp ffffffff", ffi_a); end
    n_cmp++; if (bus_a.in1 !== 64'd0) begin n_bad++; $display("FAIL reset_in1 got %h exp 0", bus_a.in1); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean;
    int unsigned cyc;
    pulse_and_wait(0, 1100, cyc);
    n_cmp++; if (cyc !== 1025) begin n_bad++; $display("FAIL clean_done_time got %0d exp 1025", cyc); end
    n_cmp++; if (pass_a !== 1'b1) begin n_bad++; $display("FAIL clean_pass got %b exp 1", pass_a); end
    n_cmp++; if (err_a !== 16'd0) begin n_bad++; $display("FAIL clean_err got %h exp 0", err_a); end
    n_cmp++; if (ffi_a !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL clean_ffi got %h exp ffffffff", ffi_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL clean_busy_done got %b exp 0", busy_a); end
  endtask

  task automatic test_stimulus;
    logic [63:0] m;
    @(negedge clk); st[1] = 1'b1;
    @(posedge clk); #1 st[1] = 1'b0;
    n_cmp++; if (busy_b !== 1'b1) begin n_bad++; $display("FAIL stim_busy got %b exp 1", busy_b); end
    n_cmp++; if (bus_b.in1 !== 64'hACE1_0000_0000_0001) begin n_bad++; $display("FAIL stim_v0_in1 got %h exp ace1000000000001", bus_b.in1); end
    n_cmp++; if (bus_b.in2 !== 64'h0000_0001_ACE1_0000) begin n_bad++; $display("FAIL stim_v0_in2 got %h exp 00000001ace10000", bus_b.in2); end
    @(posedge clk); #1;
    n_cmp++; if (bus_b.in1 !== 64'h59C2_0000_0000_0002) begin n_bad++; $display("FAIL stim_v1_in1 got %h exp 59c2000000000002", bus_b.in1); end
    n_cmp++; if (bus_b.in2 !== 64'h0000_0002_59C2_0000) begin n_bad++; $display("FAIL stim_v1_in2 got %h exp 0000000259c20000", bus_b.in2); end
    m = m_step(SEED);
    for (int k = 2; k < 4; k++) begin
      @(posedge clk); #1;
      m = m_step(m);
      n_cmp++; if (bus_b.in1 !== m) begin n_bad++; $display("FAIL stim_v%0d_in1 got %h exp %h", k, bus_b.in1, m); end
      n_cmp++; if (bus_b.in2 !== m_rot(m)) begin n_bad++; $display("FAIL stim_v%0d_in2 got %h exp %h", k, bus_b.in2, m_rot(m)); end
    end
    @(posedge clk); #1;
    n_cmp++; if (done_b !== 1'b1) begin n_bad++; $display("FAIL stim_done got %b exp 1", done_b); end
    n_cmp++; if (pass_b !== 1'b1) begin n_bad++; $display("FAIL stim_pass got %b exp 1", pass_b); end
    n_cmp++; if (bus_b.in1 !== 64'd0) begin n_bad++; $display("FAIL stim_in1_idle got %h exp 0", bus_b.in1); end
  endtask

  task automatic test_full_fault;
    int unsigned cyc;
    pulse_and_wait(2, 100, cyc);
    n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL full_done_time got %0d exp 17", cyc); end
    n_cmp++; if (err_c !== 16'd16) begin n_bad++; $display("FAIL full_err got %0d exp 16", err_c); end
    n_cmp++; if (ffi_c !== 32'd0) begin n_bad++; $display("FAIL full_ffi got %h exp 0", ffi_c); end
    n_cmp++; if (pass_c !== 1'b0) begin n_bad++; $display("FAIL full_pass got %b exp 0", pass_c); end
  endtask

  task automatic test_saturation;
    int unsigned cyc;
    pulse_and_wait(3, 100, cyc);
    n_cmp++; if (cyc !== 21) begin n_bad++; $display("FAIL sat_done_time got %0d exp 21", cyc); end
    n_cmp++; if (err_d !== 4'hF) begin n_bad++; $display("FAIL sat_err got %h exp f", err_d); end
    n_cmp++; if (ffi_d !== 32'd0) begin n_bad++; $display("FAIL sat_ffi got %h exp 0", ffi_d); end
    n_cmp++; if (pass_d !== 1'b0) begin n_bad++; $display("FAIL sat_pass got %b exp 0", pass_d); end
  endtask

  task automatic test_single_fault;
    int unsigned cyc;
    a_fault = 1'b1;
    pulse_and_wait(0, 1100, cyc);
    n_cmp++; if (err_a !== 16'd1) begin n_bad++; $display("FAIL single_err got %0d exp 1", err_a); end
    n_cmp++; if (ffi_a !== 32'd7) begin n_bad++; $display("FAIL single_ffi got %0d exp 7", ffi_a); end
    n_cmp++; if (pass_a !== 1'b0) begin n_bad++; $display("FAIL single_pass got %b exp 0", pass_a); end
  endtask

  task automatic test_restart;
    int unsigned cyc;
    a_fault = 1'b0;
    @(negedge clk); st[0] = 1'b1;
    @(posedge clk); cyc = 1; #1 st[0] = 1'b0;
    n_cmp++; if (err_a !== 16'd0) begin n_bad++; $display("FAIL restart_err_clr got %0d exp 0", err_a); end
    n_cmp++; if (ffi_a !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL restart_ffi_clr got %h exp ffffffff", ffi_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL restart_done_drop got %b exp 0", done_a); end
    n_cmp++; if (bus_a.in1 !== SEED) begin n_bad++; $display("FAIL restart_v0 got %h exp %h", bus_a.in1, SEED); end
    while (!done_a && cyc < 1100) begin
      @(posedge clk); cyc++; #1;
      st[0] = (cyc == 50);
      if (cyc == 2) begin
        n_cmp++; if (bus_a.in1 !== 64'h59C2_0000_0000_0002) begin n_bad++; $display("FAIL restart_v1 got %h exp 59c2000000000002", bus_a.in1); end
      end
    end
    st[0] = 1'b0;
    n_cmp++; if (cyc !== 1025) begin n_bad++; $display("FAIL restart_done_time got %0d exp 1025", cyc); end
    n_cmp++; if (pass_a !== 1'b1) begin n_bad++; $display("FAIL restart_pass got %b exp 1", pass_a); end
  endtask

  task automatic test_latency;
    int unsigned cyc;
    pulse_and_wait(4, 100, cyc);
    n_cmp++; if (cyc !== 18) begin n_bad++; $display("FAIL lat1_done_time got %0d exp 18", cyc); end
    n_cmp++; if (pass_e !== 1'b1) begin n_bad++; $display("FAIL lat1_pass got %b exp 1", pass_e); end
    n_cmp++; if (err_e !== 16'd0) begin n_bad++; $display("FAIL lat1_err got %0d exp 0", err_e); end
    pulse_and_wait(5, 100, cyc);
    n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL lat0_done_time got %0d exp 17", cyc); end
    n_cmp++; if (pass_f !== 1'b0) begin n_bad++; $display("FAIL lat0_pass got %b exp 0", pass_f); end
    n_cmp++; if (err_f !== 16'd16) begin n_bad++; $display("FAIL lat0_err got %0d exp 16", err_f); end
  endtask

  task automatic test_reset_midrun;
    a_fault = 1'b1;
    @(negedge clk); st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre got %b exp 1", busy_a); end
    n_cmp++; if (err_a !== 16'd1) begin n_bad++; $display("FAIL mid_err_pre got %0d exp 1", err_a); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b exp 0", busy_a); end
    n_cmp++; if (bus_a.in1 !== 64'd0) begin n_bad++; $display("FAIL mid_in1 got %h exp 0", bus_a.in1); end
    n_cmp++; if (bus_a.in2 !== 64'd0) begin n_bad++; $display("FAIL mid_in2 got %h exp 0", bus_a.in2); end
    n_cmp++; if (err_a !== 16'd0) begin n_bad++; $display("FAIL mid_err got %0d exp 0", err_a); end
    n_cmp++; if (ffi_a !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mid_ffi got %h exp ffffffff", ffi_a); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL mid_idle_after got %b exp 0", busy_a); end
    a_fault = 1'b0;
  endtask

  initial begin
    v7 = SEED;
    for (int i = 0; i < 7; i++) v7 = m_step(v7);
    test_reset();
    test_clean();
    test_stimulus();
    test_full_fault();
    test_saturation();
    test_single_fault();
    test_restart();
    test_latency();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- On-chip stimulus generator and response checker for the INV/NAND2 gate library.
- Replaces the external C testbench: drives `in1`/`in2` into the gate DUTs and checks `out_inv` and `out_nand2` against expected values.
- Reports pass/fail, an error count and the index of the first failing vector.
- Sits beside the gate DUTs in the verification top, so gate regressions can run as a free-running simulation or on FPGA.

Parameters:
- WIDTH, 64, data width of the DUT buses; legal 1..64.
- NUM_VECTORS, 1024, vectors applied per run; legal 1..2^31-1.
- LATENCY, 0, clock cycles from driving `in1`/`in2` to valid DUT outputs; legal 0..4.
- SEED, 64'hACE1_0000_0000_0001, LFSR reload value; must be nonzero.
- ERR_W, 16, width of the error counter.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a run; sampled only in IDLE or DONE.
- in1, output, WIDTH, stimulus operand A to the DUTs.
- in2, output, WIDTH, stimulus operand B to the DUTs.
- out_inv, input, WIDTH, response from the INV DUT.
- out_nand2, input, WIDTH, response from the NAND2 DUT.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, high in DONE.
- pass, output, 1, `done && err_count==0`.
- err_count, output, ERR_W, number of failing vectors; saturates at all-ones.
- first_fail_idx, output, 32, index of the first failing vector; all-ones if no failure.

Behaviour:
- **Reset** (`rst_n` low, asynchronous; takes effect immediately, including mid-run):
  - state=IDLE, LFSR=SEED, `in1`=`in2`=0.
  - `busy`=`done`=`pass`=0, `err_count`=0, `first_fail_idx`=32'hFFFF_FFFF.
  - Delay pipeline is cleared.
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE/DONE with `start`=1:**
  - Go to RUN.
  - LFSR, vector counter `vidx`, `err_count` and `first_fail_idx` are reinitialised.
  - `done` drops.
- **Start ignored:** `start` is ignored in RUN and DRAIN.
- **RUN, timing:** lasts exactly NUM_VECTORS cycles; vector k is driven during the k-th RUN cycle (k=0 is the first RUN cycle).
- **RUN, stimulus encoding:**
  - `in1` = `lfsr[WIDTH-1:0]`.
  - `in2` = `rotl(lfsr,32)[WIDTH-1:0]`, where `rotl(x,32)` = `{x[31:0],x[63:32]}`.
  - Both are registered outputs.
- **LFSR:** 64-bit Fibonacci, taps 64,63,61,60.
  - feedback = `l[63]^l[62]^l[60]^l[59]`; `l_next` = `{l[62:0],feedback}`.
  - Vector 0 uses SEED; the LFSR advances once per RUN cycle.
- **Expected values:** `exp_inv` = `~in1`; `exp_nand` = `~(in1 & in2)`.
- **Delay pipeline:**
  - `in1`, `in2` and a valid bit pass through a LATENCY-deep pipeline.
  - Vector k is compared in the cycle k+LATENCY after its drive cycle.
  - With LATENCY=0 the compare is combinational, in the same cycle the vector is driven.
- **Failure rule:** a vector fails if `out_inv != exp_inv` OR `out_nand2 != exp_nand`; one failing vector adds exactly 1 to `err_count`.
- **On a failing compare:**
  - `err_count` += 1, saturating at 2^ERR_W-1.
  - If `first_fail_idx` is all-ones, it captures k.
- **DRAIN:** after the last RUN cycle, DRAIN lasts LATENCY cycles; for LATENCY=0 it is skipped and the FSM goes RUN→DONE.
- **Outputs outside RUN:** `in1`=`in2`=0 in IDLE, DRAIN and DONE.
- **DONE:** `done`=1 and `pass` valid, held until reset or the next `start`.
- **Overall timing:** the cycle after `start` is sampled, `busy`=1; `done` rises NUM_VECTORS+LATENCY+1 clocks after the `start` edge.

Test Plan:
- **Clean run.** Correct INV/NAND2 DUT, LATENCY=0, NUM_VECTORS=1024, pulse `start` → `done` 1025 clocks after the start edge, `pass`=1, `err_count`=0, `first_fail_idx`=FFFF_FFFF.
- **Stimulus check.** NUM_VECTORS=4, SEED default → `in1` for vectors 0..3 equals an independent C/SV model of the LFSR step; vector 0: `in1`=64'hACE1_0000_0000_0001, `in2`=64'h0000_0001_ACE1_0000.
- **Full fault.** `out_nand2` driven as `in1 & in2` (inverted DUT), NUM_VECTORS=16 → `err_count`=16, `first_fail_idx`=0, `pass`=0.
- **Saturation and single fault.**
  - ERR_W=4, NUM_VECTORS=20, all vectors failing → `err_count`=15.
  - Separately, fault injected only on vector 7 → `err_count`=1, `first_fail_idx`=7.
- **Latency.**
  - DUT registered (1 cycle) with LATENCY=1 → `pass`=1, `done` at NUM_VECTORS+2 clocks.
  - Same DUT with LATENCY=0 → `pass`=0.
- **Reset and restart.**
  - `rst_n` asserted low at RUN cycle 100 → `busy`/`in1`/`in2`/`err_count` go to 0 immediately, without a clock edge.
  - A second `start` in DONE reruns the identical vector sequence with counters cleared.
  - `start` pulsed during RUN has no effect on `done` timing.
